// File: rtl/proc_gen.sv
// Multi-cycle processor with eight registers, accumulator A and result G.
// Each instruction is sequenced by a 2-bit step counter over one shared bus.
module proc_gen #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [W-1:0] DIN,
  input  logic         Run,
  output logic         Done,
  output logic [W-1:0] BusWires
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MVNZ = 3'b111;

  step_t        r_step;
  logic [8:0]   r_ir;
  logic [W-1:0] r_a;
  logic [W-1:0] r_g;
  logic         r_z;
  logic [W-1:0] r_reg [8];

  logic [2:0]   w_op;
  logic [2:0]   w_x;
  logic [2:0]   w_y;
  logic         w_alu;
  logic [W-1:0] w_alu_res;
  logic [W-1:0] w_bus;
  logic         w_done;

  function automatic logic [W-1:0] f_alu(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      OP_ADD:  f_alu = a + b;
      OP_SUB:  f_alu = a - b;
      OP_AND:  f_alu = a & b;
      OP_OR:   f_alu = a | b;
      OP_XOR:  f_alu = a ^ b;
      default: f_alu = {W{1'b0}};
    endcase
  endfunction

  assign w_op      = r_ir[8:6];
  assign w_x       = r_ir[5:3];
  assign w_y       = r_ir[2:0];
  assign w_alu     = (w_op != OP_MV) && (w_op != OP_MVI) && (w_op != OP_MVNZ);
  assign w_alu_res = f_alu(w_op, r_a, w_bus);

  // Bus source select; steps that do not use the bus drive zero.
  always_comb begin
    w_bus = {W{1'b0}};
    case (r_step)
      T0: w_bus = DIN;
      T1: begin
        case (w_op)
          OP_MV, OP_MVNZ: w_bus = r_reg[w_y];
          OP_MVI:         w_bus = DIN;
          default:        w_bus = r_reg[w_x];
        endcase
      end
      T2: begin
        if (w_alu) w_bus = r_reg[w_y];
        else       w_bus = {W{1'b0}};
      end
      T3: begin
        if (w_alu) w_bus = r_g;
        else       w_bus = {W{1'b0}};
      end
      default: w_bus = {W{1'b0}};
    endcase
  end

  // Done marks the last step: T1 for moves, T3 for ALU ops.
  always_comb begin
    w_done = 1'b0;
    case (r_step)
      T1:      w_done = !w_alu;
      T3:      w_done = w_alu;
      default: w_done = 1'b0;
    endcase
  end

  assign BusWires = w_bus;
  assign Done     = w_done;

  // Step sequencer and all architectural state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_step <= T0;
      r_ir   <= 9'd0;
      r_a    <= {W{1'b0}};
      r_g    <= {W{1'b0}};
      r_z    <= 1'b1;
      for (int i = 0; i < 8; i++) r_reg[i] <= {W{1'b0}};
    end else begin
      case (r_step)
        T0: begin
          if (Run) begin
            r_ir   <= DIN[8:0];
            r_step <= T1;
          end
        end
        T1: begin
          case (w_op)
            OP_MV, OP_MVI: begin
              r_reg[w_x] <= w_bus;
              r_step     <= T0;
            end
            OP_MVNZ: begin
              if (!r_z) r_reg[w_x] <= w_bus;
              r_step <= T0;
            end
            default: begin
              r_a    <= w_bus;
              r_step <= T2;
            end
          endcase
        end
        T2: begin
          if (w_alu) begin
            r_g    <= w_alu_res;
            r_z    <= (w_alu_res == {W{1'b0}});
            r_step <= T3;
          end else begin
            r_step <= T0;
          end
        end
        T3: begin
          if (w_alu) r_reg[w_x] <= w_bus;
          r_step <= T0;
        end
        default: r_step <= T0;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_gen.sv
// Randomized self-checking bench for proc_gen against a register-level model.
module tb_proc_gen;

  localparam int W = 16;

  logic         Clock;
  logic         Resetn;
  logic [W-1:0] DIN;
  logic         Run;
  logic         Done;
  logic [W-1:0] BusWires;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_reg [8];
  logic         m_z;

  proc_gen #(.W(W)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .DIN      (DIN),
    .Run      (Run),
    .Done     (Done),
    .BusWires (BusWires)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_z = 1'b1;
  endtask

  // Runs one instruction from T0; each task call starts 1 time unit after a rising edge.
  task automatic exec(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                      input logic [W-1:0] imm, output logic [W-1:0] last_bus);
    logic [W-1:0] instr, a, b, res;
    logic [6:0]   junk;
    junk  = 7'($urandom);
    instr = {junk, op, x, y};
    DIN = instr; Run = 1'b1;
    #1;
    total++;
    if (Done !== 1'b0 || BusWires !== instr) begin
      bad++; $display("FAIL fetch: done=%b bus=%h want done=0 bus=%h", Done, BusWires, instr);
    end
    @(posedge Clock); #1;
    Run = 1'($urandom);
    if (op == 3'b001) DIN = imm; else DIN = W'($urandom);
    #1;
    if (op == 3'b000 || op == 3'b001 || op == 3'b111) begin
      if (op == 3'b001) res = imm; else res = m_reg[y];
      total++;
      if (Done !== 1'b1 || BusWires !== res) begin
        bad++; $display("FAIL t1_move op=%0d: done=%b bus=%h want done=1 bus=%h", op, Done, BusWires, res);
      end
      if (op != 3'b111 || m_z == 1'b0) m_reg[x] = res;
      last_bus = BusWires;
      @(posedge Clock); #1;
    end else begin
      a = m_reg[x];
      total++;
      if (Done !== 1'b0 || BusWires !== a) begin
        bad++; $display("FAIL t1_alu op=%0d: done=%b bus=%h want done=0 bus=%h", op, Done, BusWires, a);
      end
      @(posedge Clock); #1;
      Run = 1'($urandom); DIN = W'($urandom); #1;
      b = m_reg[y];
      total++;
      if (Done !== 1'b0 || BusWires !== b) begin
        bad++; $display("FAIL t2_alu op=%0d: done=%b bus=%h want done=0 bus=%h", op, Done, BusWires, b);
      end
      case (op)
        3'b010:  res = a + b;
        3'b011:  res = a - b;
        3'b100:  res = a & b;
        3'b101:  res = a | b;
        default: res = a ^ b;
      endcase
      @(posedge Clock); #1;
      Run = 1'($urandom); DIN = W'($urandom); #1;
      total++;
      if (Done !== 1'b1 || BusWires !== res) begin
        bad++; $display("FAIL t3_alu op=%0d: done=%b bus=%h want done=1 bus=%h", op, Done, BusWires, res);
      end
      m_reg[x] = res;
      m_z = (res == '0);
      last_bus = BusWires;
      @(posedge Clock); #1;
    end
    Run = 1'b0;
  endtask

  task automatic idle_cycle();
    DIN = W'($urandom); Run = 1'b0; #1;
    total++;
    if (Done !== 1'b0 || BusWires !== DIN) begin
      bad++; $display("FAIL idle: done=%b bus=%h want done=0 bus=%h", Done, BusWires, DIN);
    end
    @(posedge Clock); #1;
  endtask

  // Makes Z visible: R6 ends as 0x0055 when Z=1, 0x00AA when Z=0.
  task automatic z_probe(output logic [W-1:0] obs);
    logic [W-1:0] b;
    exec(3'b001, 3'd6, 3'd0, 16'h0055, b);
    exec(3'b001, 3'd7, 3'd0, 16'h00AA, b);
    exec(3'b111, 3'd6, 3'd7, '0, b);
    exec(3'b000, 3'd6, 3'd6, '0, obs);
  endtask

  task automatic test_reset();
    logic [W-1:0] obs;
    Resetn = 1'b0; Run = 1'b1; DIN = 16'h0023;
    model_reset();
    #1;
    total++;
    if (Done !== 1'b0 || BusWires !== 16'h0023) begin
      bad++; $display("FAIL reset_out: done=%b bus=%h want done=0 bus=0023", Done, BusWires);
    end
    repeat (3) @(posedge Clock);
    #1; Resetn = 1'b1; Run = 1'b0;
    exec(3'b000, 3'd3, 3'd3, '0, obs);
    total++;
    if (obs !== 16'h0000) begin bad++; $display("FAIL reset_r3: got %h want 0000", obs); end
    for (int k = 0; k < 8; k++) begin
      exec(3'b000, 3'(k), 3'(k), '0, obs);
      total++;
      if (obs !== 16'h0000) begin bad++; $display("FAIL reset_reg%0d: got %h want 0000", k, obs); end
    end
    z_probe(obs);
    total++;
    if (obs !== 16'h0055) begin bad++; $display("FAIL reset_z: probe %h want 0055", obs); end
  endtask

  task automatic test_mvi();
    logic [W-1:0] obs;
    exec(3'b001, 3'd0, 3'd0, 16'h0005, obs);
    total++;
    if (obs !== 16'h0005) begin bad++; $display("FAIL mvi_bus: got %h want 0005", obs); end
    idle_cycle();
    exec(3'b000, 3'd0, 3'd0, '0, obs);
    total++;
    if (obs !== 16'h0005) begin bad++; $display("FAIL mvi_r0: got %h want 0005", obs); end
  endtask

  task automatic test_add();
    logic [W-1:0] obs;
    exec(3'b001, 3'd1, 3'd0, 16'hFFFF, obs);
    exec(3'b001, 3'd0, 3'd0, 16'h0005, obs);
    exec(3'b010, 3'd1, 3'd0, '0, obs);
    total++;
    if (obs !== 16'h0004) begin bad++; $display("FAIL add_wrap: got %h want 0004", obs); end
    exec(3'b000, 3'd1, 3'd1, '0, obs);
    total++;
    if (obs !== 16'h0004) begin bad++; $display("FAIL add_r1: got %h want 0004", obs); end
    z_probe(obs);
    total++;
    if (obs !== 16'h00AA) begin bad++; $display("FAIL add_z: probe %h want 00aa", obs); end
  endtask

  task automatic test_sub_mvnz();
    logic [W-1:0] obs;
    exec(3'b011, 3'd0, 3'd0, '0, obs);
    total++;
    if (obs !== 16'h0000) begin bad++; $display("FAIL sub_self: got %h want 0000", obs); end
    exec(3'b001, 3'd2, 3'd0, 16'h1234, obs);
    exec(3'b001, 3'd1, 3'd0, 16'h0777, obs);
    exec(3'b111, 3'd2, 3'd1, '0, obs);
    exec(3'b000, 3'd2, 3'd2, '0, obs);
    total++;
    if (obs !== 16'h1234) begin bad++; $display("FAIL mvnz_hold: got %h want 1234", obs); end
    exec(3'b010, 3'd1, 3'd1, '0, obs);
    exec(3'b111, 3'd2, 3'd1, '0, obs);
    exec(3'b000, 3'd2, 3'd2, '0, obs);
    total++;
    if (obs !== 16'h0EEE) begin bad++; $display("FAIL mvnz_move: got %h want 0eee", obs); end
  endtask

  task automatic test_logic();
    logic [W-1:0] obs;
    logic [2:0]   ops  [3];
    logic [W-1:0] want [3];
    ops[0] = 3'b100; want[0] = 16'h00F0;
    ops[1] = 3'b101; want[1] = 16'hFFF0;
    ops[2] = 3'b110; want[2] = 16'hFF00;
    for (int i = 0; i < 3; i++) begin
      exec(3'b001, 3'd0, 3'd0, 16'hF0F0, obs);
      exec(3'b001, 3'd1, 3'd0, 16'h0FF0, obs);
      exec(ops[i], 3'd0, 3'd1, '0, obs);
      exec(3'b000, 3'd0, 3'd0, '0, obs);
      total++;
      if (obs !== want[i]) begin bad++; $display("FAIL logic_op%0d: got %h want %h", ops[i], obs, want[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] obs;
    for (int n = 0; n < 60; n++) begin
      exec(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), W'($urandom), obs);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
    for (int k = 0; k < 8; k++) begin
      exec(3'b000, 3'(k), 3'(k), '0, obs);
      total++;
      if (obs !== m_reg[k]) begin bad++; $display("FAIL rand_reg%0d: got %h want %h", k, obs, m_reg[k]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] obs;
    exec(3'b001, 3'd1, 3'd0, 16'hFFFF, obs);
    exec(3'b001, 3'd0, 3'd0, 16'h0005, obs);
    DIN = 16'h0088; Run = 1'b1;
    @(posedge Clock); #1;
    Run = 1'b0; DIN = W'($urandom);
    @(posedge Clock); #1;
    Resetn = 1'b0; DIN = 16'h3C3C;
    model_reset();
    #1;
    total++;
    if (Done !== 1'b0 || BusWires !== 16'h3C3C) begin
      bad++; $display("FAIL midreset_out: done=%b bus=%h want done=0 bus=3c3c", Done, BusWires);
    end
    repeat (2) @(posedge Clock);
    #1; Resetn = 1'b1;
    repeat (5) idle_cycle();
    exec(3'b000, 3'd1, 3'd1, '0, obs);
    total++;
    if (obs !== 16'h0000) begin bad++; $display("FAIL midreset_r1: got %h want 0000", obs); end
    z_probe(obs);
    total++;
    if (obs !== 16'h0055) begin bad++; $display("FAIL midreset_z: probe %h want 0055", obs); end
  endtask

  initial begin
    Resetn = 1'b0; Run = 1'b0; DIN = '0;
    test_reset();
    test_mvi();
    test_add();
    test_sub_mvnz();
    test_logic();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
